fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_sync.sv | 68 ++++++
 rtl/skid_buffer_2.sv | 49 ++++
 rtl/fifo_burst_reader.sv | 106 ++++++++++
 tb/tb_fifo_burst_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the FIFO burst reader slice.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 6;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int SKID_DEPTH      = 2;
    localparam int SKID_CNT_WIDTH  = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } burst_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO feeding the burst reader; FALL selects show-ahead or registered read data.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int FALL       = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_pop,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (ADDR_WIDTH + 1)'(DEPTH));
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    if (FALL != 0) begin : g_fwft
        assign data_pop = mem[rd_ptr];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_q;

        // Registered read: the popped word appears on the cycle after the pop.
        always_ff @(posedge clk) begin
            if (rst)         rd_q <= '0;
            else if (do_pop) rd_q <= mem[rd_ptr];
        end

        assign data_pop = rd_q;
    end

endmodule

// File: rtl/skid_buffer_2.sv
// Two-entry output buffer; the head entry stays put until it is popped.
module skid_buffer_2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      pop,
    output logic                      valid,
    output logic [DATA_WIDTH-1:0]     data,
    output logic [SKID_CNT_WIDTH-1:0] count
);
    logic [DATA_WIDTH-1:0]     mem [SKID_DEPTH];
    logic                      wr_ptr, rd_ptr;
    logic [SKID_CNT_WIDTH-1:0] cnt_q;
    logic                      do_push, do_pop;

    assign do_push = push && (cnt_q != SKID_CNT_WIDTH'(SKID_DEPTH));
    assign do_pop  = pop && (cnt_q != '0);

    // Entry storage, ring pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign valid = (cnt_q != '0);
    assign data  = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a fixed-length burst out of a FIFO into a ready/valid stream.
//
// state     | meaning
// ST_IDLE   | waiting for start; burst length captured on start
// ST_WAIT   | waiting until the FIFO holds the whole burst
// ST_STREAM | popping words and handing them downstream
// ST_DONE   | one-cycle completion pulse
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int FALL       = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_pop,
    input  logic                  empty,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    burst_state_t              state_q, state_d;
    logic [ADDR_WIDTH:0]       len_q, pop_left_q, xfer_left_q, len_clamped;
    logic                      inflight_q, xfer, skid_push;
    logic [SKID_CNT_WIDTH-1:0] skid_count;
    logic [SKID_CNT_WIDTH:0]   occupancy;

    assign len_clamped = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
    assign xfer        = out_valid && out_ready;
    // Words already committed to the skid buffer, including one still in the FIFO read register.
    assign occupancy   = {1'b0, skid_count} + {{SKID_CNT_WIDTH{1'b0}}, inflight_q};
    assign skid_push   = (FALL != 0) ? pop : inflight_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_WAIT;
            ST_WAIT: begin
                if (len_q == '0)         state_d = ST_DONE;
                else if (count >= len_q) state_d = ST_STREAM;
            end
            ST_STREAM: if (xfer && (xfer_left_q == (ADDR_WIDTH + 1)'(1))) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs; pop is held off whenever two words are already committed downstream.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
        pop  = 1'b0;
        if (state_q == ST_STREAM && !empty && pop_left_q != '0
            && occupancy < (SKID_CNT_WIDTH + 1)'(SKID_DEPTH)) begin
            pop = 1'b1;
        end
    end

    // Burst length and the two remaining-word down-counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            pop_left_q  <= '0;
            xfer_left_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                len_q       <= len_clamped;
                pop_left_q  <= len_clamped;
                xfer_left_q <= len_clamped;
            end else begin
                if (pop)  pop_left_q  <= pop_left_q - 1'b1;
                if (xfer) xfer_left_q <= xfer_left_q - 1'b1;
            end
            inflight_q <= (FALL == 0) && pop;
        end
    end

    skid_buffer_2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (skid_push),
        .push_data (data_pop),
        .pop       (xfer),
        .valid     (out_valid),
        .data      (out_data),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench: instance 0 uses a show-ahead FIFO (FALL=1), instance 1 a registered-read FIFO (FALL=0).
module tb_fifo_burst_reader;
    import fifo_pkg::*;

    localparam int DW = FIFO_DATA_WIDTH;
    localparam int AW = FIFO_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    start_s, busy_s, done_s, pop_s, empty_s, full_s, push_s, out_valid_s, out_ready_s;
    logic [AW:0]   len_s [2];
    logic [AW:0]   count_s [2];
    logic [DW-1:0] wdata_s [2];
    logic [DW-1:0] data_pop_s [2];
    logic [DW-1:0] out_data_s [2];

    logic [DW-1:0] exp_q [2][$];
    int            pop_cnt [2];
    int            done_cnt [2];
    int            xfer_cnt [2];
    int            occ [2];
    logic          stall_q [2];
    logic [DW-1:0] stall_data [2];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fifo_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FALL(g == 0 ? 1 : 0)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_s[g]),
            .push_data (wdata_s[g]),
            .pop       (pop_s[g]),
            .data_pop  (data_pop_s[g]),
            .empty     (empty_s[g]),
            .full      (full_s[g]),
            .count     (count_s[g])
        );
        fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FALL(g == 0 ? 1 : 0)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_s[g]),
            .burst_len (len_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g]),
            .pop       (pop_s[g]),
            .data_pop  (data_pop_s[g]),
            .empty     (empty_s[g]),
            .count     (count_s[g]),
            .out_valid (out_valid_s[g]),
            .out_data  (out_data_s[g]),
            .out_ready (out_ready_s[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor: scoreboard, stall stability, pop legality, event counters.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                occ[u]     = 0;
                stall_q[u] = 1'b0;
            end else begin
                check("pop_while_empty", {31'd0, pop_s[u] & empty_s[u]}, 0);
                check("pop_while_idle", {31'd0, pop_s[u] & ~busy_s[u]}, 0);
                if (pop_s[u]) begin
                    check("pop_with_skid_full", {31'd0, occ[u] < 2}, 1);
                    pop_cnt[u]++;
                end
                if (stall_q[u]) begin
                    check("stall_valid", {31'd0, out_valid_s[u]}, 1);
                    check("stall_data", {26'd0, out_data_s[u]}, {26'd0, stall_data[u]});
                end
                if (out_valid_s[u] && out_ready_s[u]) begin
                    xfer_cnt[u]++;
                    check("word_expected", {31'd0, exp_q[u].size() > 0}, 1);
                    if (exp_q[u].size() > 0)
                        check("out_data", {26'd0, out_data_s[u]}, {26'd0, exp_q[u].pop_front()});
                end
                if (done_s[u]) done_cnt[u]++;
                occ[u]        = occ[u] + int'(pop_s[u]) - int'(out_valid_s[u] & out_ready_s[u]);
                stall_q[u]    = out_valid_s[u] & ~out_ready_s[u];
                stall_data[u] = out_data_s[u];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int u, input logic [DW-1:0] w);
        push_s[u]  = 1'b1;
        wdata_s[u] = w;
        exp_q[u].push_back(w);
        tick();
        push_s[u]  = 1'b0;
    endtask

    // Optionally pulses start, then waits for done; times are in cycles from entry.
    task automatic run_burst(input int u, input logic [AW:0] len, input bit do_start, input bit toggle,
                             output int t_pop, output int t_valid, output int t_done);
        int t0;
        t_pop = -1; t_valid = -1; t_done = -1;
        t0 = cyc;
        start_s[u] = do_start;
        len_s[u]   = len;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (t_pop < 0 && pop_s[u])         t_pop = cyc - t0;
            if (t_valid < 0 && out_valid_s[u]) t_valid = cyc - t0;
            if (done_s[u]) begin
                t_done = cyc - t0;
                break;
            end
            tick();
            start_s[u] = 1'b0;
            if (toggle) out_ready_s[u] = ~out_ready_s[u];
        end
        start_s[u] = 1'b0;
        check("done_within_budget", {31'd0, t_done >= 0}, 1);
        tick();
        out_ready_s[u] = 1'b1;
    endtask

    task automatic check_quiet(input int u, input string tag);
        check({tag, "_busy"}, {31'd0, busy_s[u]}, 0);
        check({tag, "_done"}, {31'd0, done_s[u]}, 0);
        check({tag, "_pop"}, {31'd0, pop_s[u]}, 0);
        check({tag, "_out_valid"}, {31'd0, out_valid_s[u]}, 0);
        check({tag, "_out_data"}, {26'd0, out_data_s[u]}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            t_pop, t_valid, t_done, pb, db, xb;
        logic [DW-1:0] w1 [5];

        rst         = 1'b1;
        start_s     = '0;
        push_s      = '0;
        out_ready_s = 2'b11;
        for (int u = 0; u < 2; u++) begin
            len_s[u]   = '0;
            wdata_s[u] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        check_quiet(0, "reset0");
        check_quiet(1, "reset1");

        // Burst of 5 with out_ready high.
        for (int i = 0; i < 5; i++) begin
            w1[i] = DW'($urandom_range(0, (1 << DW) - 1));
            push_word(0, w1[i]);
        end
        pb = pop_cnt[0]; db = done_cnt[0];
        run_burst(0, 5, 1'b1, 1'b0, t_pop, t_valid, t_done);
        tick();
        check("s1_first_pop", t_pop, 2);
        check("s1_first_valid", t_valid, 3);
        check("s1_done_time", t_done, 8);
        check("s1_pops", pop_cnt[0] - pb, 5);
        check("s1_done_pulses", done_cnt[0] - db, 1);
        check("s1_fifo_empty", {31'd0, empty_s[0]}, 1);
        check("s1_all_delivered", exp_q[0].size(), 0);
        check("s1_busy_after", {31'd0, busy_s[0]}, 0);

        // Burst of 8 with only 5 words available; a second start while waiting is ignored.
        for (int i = 0; i < 5; i++) push_word(0, DW'($urandom_range(0, (1 << DW) - 1)));
        pb = pop_cnt[0]; db = done_cnt[0];
        start_s[0] = 1'b1; len_s[0] = 8; tick(); start_s[0] = 1'b0;
        repeat (4) tick();
        start_s[0] = 1'b1; len_s[0] = 1; tick(); start_s[0] = 1'b0;
        repeat (4) tick();
        check("s2_no_pop_waiting", pop_cnt[0] - pb, 0);
        check("s2_busy_waiting", {31'd0, busy_s[0]}, 1);
        check("s2_no_valid_waiting", {31'd0, out_valid_s[0]}, 0);
        for (int i = 0; i < 3; i++) push_word(0, DW'($urandom_range(0, (1 << DW) - 1)));
        run_burst(0, 8, 1'b0, 1'b0, t_pop, t_valid, t_done);
        tick();
        check("s2_pops", pop_cnt[0] - pb, 8);
        check("s2_all_delivered", exp_q[0].size(), 0);
        check("s2_done_pulses", done_cnt[0] - db, 1);

        // Full FIFO, burst_len 20 clamps to 16, out_ready toggling.
        for (int i = 0; i < 16; i++) push_word(0, DW'($urandom_range(0, (1 << DW) - 1)));
        pb = pop_cnt[0]; db = done_cnt[0];
        run_burst(0, 20, 1'b1, 1'b1, t_pop, t_valid, t_done);
        tick();
        check("s3_first_pop", t_pop, 2);
        check("s3_pops", pop_cnt[0] - pb, 16);
        check("s3_all_delivered", exp_q[0].size(), 0);
        check("s3_done_pulses", done_cnt[0] - db, 1);
        check("s3_fifo_empty", {31'd0, empty_s[0]}, 1);

        // Zero-length bursts, the second started on the cycle after done.
        pb = pop_cnt[0]; db = done_cnt[0];
        run_burst(0, 0, 1'b1, 1'b0, t_pop, t_valid, t_done);
        check("s4_done_time", t_done, 2);
        run_burst(0, 0, 1'b1, 1'b0, t_pop, t_valid, t_done);
        check("s4_restart_done_time", t_done, 2);
        tick();
        check("s4_no_pop", pop_cnt[0] - pb, 0);
        check("s4_done_pulses", done_cnt[0] - db, 2);
        check("s4_busy_after", {31'd0, busy_s[0]}, 0);

        // Reset after three of ten words delivered.
        for (int i = 0; i < 10; i++) push_word(0, DW'($urandom_range(0, (1 << DW) - 1)));
        xb = xfer_cnt[0]; db = done_cnt[0];
        start_s[0] = 1'b1; len_s[0] = 10; tick(); start_s[0] = 1'b0;
        for (int i = 0; i < 60 && (xfer_cnt[0] - xb) < 3; i++) tick();
        check("s5_three_delivered", xfer_cnt[0] - xb, 3);
        rst = 1'b1;
        tick();
        check_quiet(0, "s5_after_rst");
        rst = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (4) tick();
        check("s5_no_done", done_cnt[0] - db, 0);
        check("s5_idle", {31'd0, busy_s[0]}, 0);
        pb = pop_cnt[0]; db = done_cnt[0];
        for (int i = 0; i < 2; i++) push_word(0, DW'($urandom_range(0, (1 << DW) - 1)));
        run_burst(0, 2, 1'b1, 1'b0, t_pop, t_valid, t_done);
        tick();
        check("s5_pops", pop_cnt[0] - pb, 2);
        check("s5_all_delivered", exp_q[0].size(), 0);
        check("s5_done_time", t_done, 5);
        check("s5_done_pulses", done_cnt[0] - db, 1);

        // Registered-read FIFO, same five words as the first burst.
        for (int i = 0; i < 5; i++) push_word(1, w1[i]);
        pb = pop_cnt[1]; db = done_cnt[1];
        run_burst(1, 5, 1'b1, 1'b0, t_pop, t_valid, t_done);
        tick();
        check("s6_first_pop", t_pop, 2);
        check("s6_first_valid", t_valid, 4);
        check("s6_pops", pop_cnt[1] - pb, 5);
        check("s6_done_pulses", done_cnt[1] - db, 1);
        check("s6_fifo_empty", {31'd0, empty_s[1]}, 1);
        check("s6_all_delivered", exp_q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
